// File: rtl/binary_centroid_pkg.sv
// Shared types and widths for the binary_centroid frame-statistics stage.
`timescale 1ns/1ps
package binary_centroid_pkg;

   localparam int unsigned X_W   = 10;
   localparam int unsigned Y_W   = 9;
   localparam int unsigned CNT_W = 19;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      DIV_X   = 2'd1,
      DIV_Y   = 2'd2,
      PUBLISH = 2'd3
   } state_e;

   typedef struct packed {
      logic [X_W-1:0] x_min;
      logic [X_W-1:0] x_max;
      logic [Y_W-1:0] y_min;
      logic [Y_W-1:0] y_max;
   } box_t;

   // Running min starts at all-ones, running max at zero.
   localparam box_t BOX_INIT = '{x_min: '1, x_max: '0, y_min: '1, y_max: '0};

endpackage

// File: rtl/binary_centroid_seq_divider.sv
// Restoring unsigned divider, one quotient bit per cycle, MSB first.
// The first bit is produced on the start edge, so done pulses DIV_W-1 edges later.
`timescale 1ns/1ps
module seq_divider #(
   parameter int unsigned DIV_W = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [DIV_W-1:0] dividend,
   input  logic [DIV_W-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [DIV_W-1:0] quotient
);

   localparam int unsigned STEP_W = $clog2(DIV_W + 1);

   logic [DIV_W-1:0]  rem_q;
   logic [DIV_W-1:0]  dsr_q;
   logic [STEP_W-1:0] step_q;

   logic [DIV_W-1:0]  rem_in;
   logic [DIV_W-1:0]  quo_in;
   logic [DIV_W-1:0]  dsr_in;
   logic [DIV_W:0]    shifted;
   logic [DIV_W-1:0]  rem_nxt;
   logic [DIV_W-1:0]  quo_nxt;

   // One restoring step, seeded from the inputs on start.
   always_comb begin
      rem_in  = start ? '0 : rem_q;
      quo_in  = start ? dividend : quotient;
      dsr_in  = start ? divisor : dsr_q;
      shifted = {rem_in, quo_in[DIV_W-1]};
      rem_nxt = shifted[DIV_W-1:0];
      quo_nxt = {quo_in[DIV_W-2:0], 1'b0};
      if (shifted >= {1'b0, dsr_in}) begin
         rem_nxt = DIV_W'(shifted - {1'b0, dsr_in});
         quo_nxt = {quo_in[DIV_W-2:0], 1'b1};
      end
   end

   // Iteration state and the one-cycle done pulse.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rem_q    <= '0;
         dsr_q    <= '0;
         step_q   <= '0;
         quotient <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
      end else begin
         done <= 1'b0;
         if (start) begin
            rem_q    <= rem_nxt;
            quotient <= quo_nxt;
            dsr_q    <= divisor;
            step_q   <= STEP_W'(DIV_W - 1);
            busy     <= 1'b1;
         end else if (busy) begin
            rem_q    <= rem_nxt;
            quotient <= quo_nxt;
            step_q   <= step_q - STEP_W'(1);
            if (step_q == STEP_W'(1)) begin
               busy <= 1'b0;
               done <= 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/binary_centroid.sv
// Per-frame white-pixel statistics and integer centroid of a binary pixel stream.
`timescale 1ns/1ps
module binary_centroid
   import binary_centroid_pkg::*;
#(
   parameter int unsigned H_ACTIVE   = 640,
   parameter int unsigned V_ACTIVE   = 480,
   parameter int unsigned MIN_PIXELS = 64,
   parameter int unsigned DIV_W      = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             vsync_in,
   input  logic             href_in,
   input  logic [31:0]      binary_data_in,
   output logic [X_W-1:0]   x_min,
   output logic [X_W-1:0]   x_max,
   output logic [Y_W-1:0]   y_min,
   output logic [Y_W-1:0]   y_max,
   output logic [X_W-1:0]   centroid_x,
   output logic [Y_W-1:0]   centroid_y,
   output logic [CNT_W-1:0] pixel_count,
   output logic             target_valid,
   output logic             result_valid
);

   localparam logic [X_W-1:0]   H_LIM   = X_W'(H_ACTIVE);
   localparam logic [Y_W-1:0]   V_LIM   = Y_W'(V_ACTIVE);
   localparam logic [CNT_W-1:0] MIN_CNT = CNT_W'(MIN_PIXELS);

   logic             vsync_q, href_q;
   logic [X_W-1:0]   x_cnt;
   logic [Y_W-1:0]   y_cnt;
   logic [CNT_W-1:0] acc_cnt, snap_cnt;
   logic [DIV_W-1:0] acc_sx, acc_sy, snap_sx, snap_sy;
   box_t             acc_box, snap_box;
   logic [X_W-1:0]   qx_q;

   state_e           state_q, state_d;
   logic             launch_q, launch_d;
   logic             snap_c, publish_c;

   logic             frame_end_c, pix_c;
   logic             div_start_c, div_sel_y_c;
   logic [DIV_W-1:0] div_dividend_c;
   logic             div_busy, div_done;
   logic [DIV_W-1:0] div_quotient;
   logic             unused_bits;

   assign frame_end_c    = vsync_in && !vsync_q;
   assign pix_c          = href_in && (x_cnt < H_LIM) && (y_cnt < V_LIM) && binary_data_in[0];
   assign div_sel_y_c    = (state_q == DIV_X) && div_done;
   assign div_start_c    = launch_q || div_sel_y_c;
   assign div_dividend_c = div_sel_y_c ? snap_sy : snap_sx;
   assign unused_bits    = ^{binary_data_in[31:1], div_quotient[DIV_W-1:X_W], div_busy};

   // Framing edges and pixel coordinate counters (saturating past the active area).
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vsync_q <= 1'b0;
         href_q  <= 1'b0;
         x_cnt   <= '0;
         y_cnt   <= '0;
      end else begin
         vsync_q <= vsync_in;
         href_q  <= href_in;
         if (!href_in)
            x_cnt <= '0;
         else if (x_cnt != H_LIM)
            x_cnt <= x_cnt + X_W'(1);
         if (vsync_in)
            y_cnt <= '0;
         else if (href_q && !href_in && (y_cnt != V_LIM))
            y_cnt <= y_cnt + Y_W'(1);
      end
   end

   // Running accumulators; cleared on every frame end, taken or dropped.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_cnt <= '0;
         acc_sx  <= '0;
         acc_sy  <= '0;
         acc_box <= BOX_INIT;
      end else if (frame_end_c) begin
         acc_cnt <= '0;
         acc_sx  <= '0;
         acc_sy  <= '0;
         acc_box <= BOX_INIT;
      end else if (pix_c) begin
         acc_cnt <= acc_cnt + CNT_W'(1);
         acc_sx  <= acc_sx + DIV_W'(x_cnt);
         acc_sy  <= acc_sy + DIV_W'(y_cnt);
         if (x_cnt < acc_box.x_min) acc_box.x_min <= x_cnt;
         if (x_cnt > acc_box.x_max) acc_box.x_max <= x_cnt;
         if (y_cnt < acc_box.y_min) acc_box.y_min <= y_cnt;
         if (y_cnt > acc_box.y_max) acc_box.y_max <= y_cnt;
      end
   end

   // Frame snapshot held for the duration of the division.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         snap_cnt <= '0;
         snap_sx  <= '0;
         snap_sy  <= '0;
         snap_box <= '0;
      end else if (snap_c) begin
         snap_cnt <= acc_cnt;
         snap_sx  <= acc_sx;
         snap_sy  <= acc_sy;
         snap_box <= acc_box;
      end
   end

   seq_divider #(.DIV_W(DIV_W)) u_div (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (div_start_c),
      .dividend (div_dividend_c),
      .divisor  (DIV_W'(snap_cnt)),
      .busy     (div_busy),
      .done     (div_done),
      .quotient (div_quotient)
   );

   // FSM state register and the registered divider launch for DIV_X.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         launch_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         launch_q <= launch_d;
      end
   end

   // FSM next state; the Y division is launched straight off the X done pulse.
   always_comb begin
      state_d   = state_q;
      launch_d  = 1'b0;
      snap_c    = 1'b0;
      publish_c = 1'b0;
      case (state_q)
         IDLE: begin
            if (frame_end_c) begin
               snap_c   = 1'b1;
               launch_d = 1'b1;
               state_d  = DIV_X;
            end
         end
         DIV_X:   if (div_done) state_d = DIV_Y;
         DIV_Y:   if (div_done) state_d = PUBLISH;
         PUBLISH: begin
            publish_c = 1'b1;
            state_d   = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Result registers, loaded once per accepted frame.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         qx_q         <= '0;
         x_min        <= '0;
         x_max        <= '0;
         y_min        <= '0;
         y_max        <= '0;
         centroid_x   <= '0;
         centroid_y   <= '0;
         pixel_count  <= '0;
         target_valid <= 1'b0;
         result_valid <= 1'b0;
      end else begin
         result_valid <= 1'b0;
         if (div_sel_y_c)
            qx_q <= X_W'(div_quotient);
         if (publish_c) begin
            result_valid <= 1'b1;
            pixel_count  <= snap_cnt;
            target_valid <= (snap_cnt != '0) && (snap_cnt >= MIN_CNT);
            if (snap_cnt == '0) begin
               x_min      <= '0;
               x_max      <= '0;
               y_min      <= '0;
               y_max      <= '0;
               centroid_x <= '0;
               centroid_y <= '0;
            end else begin
               x_min      <= snap_box.x_min;
               x_max      <= snap_box.x_max;
               y_min      <= snap_box.y_min;
               y_max      <= snap_box.y_max;
               centroid_x <= qx_q;
               centroid_y <= Y_W'(div_quotient);
            end
         end
      end
   end

endmodule

// File: tb/tb_binary_centroid.sv
// Directed bench for binary_centroid: vector table of small frames plus
// hand sequences for dropped frame ends and reset during division.
`timescale 1ns/1ps
module tb_binary_centroid;
   import binary_centroid_pkg::*;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             vsync_in = 1'b0;
   logic             href_in = 1'b0;
   logic [31:0]      binary_data_in = '0;
   logic [X_W-1:0]   x_min, x_max, centroid_x;
   logic [Y_W-1:0]   y_min, y_max, centroid_y;
   logic [CNT_W-1:0] pixel_count;
   logic             target_valid, result_valid;

   binary_centroid dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .vsync_in       (vsync_in),
      .href_in        (href_in),
      .binary_data_in (binary_data_in),
      .x_min          (x_min),
      .x_max          (x_max),
      .y_min          (y_min),
      .y_max          (y_max),
      .centroid_x     (centroid_x),
      .centroid_y     (centroid_y),
      .pixel_count    (pixel_count),
      .target_valid   (target_valid),
      .result_valid   (result_valid)
   );

   always #5 clk = ~clk;

   typedef struct {
      int y0, nrows, len, wx0, wx1;
      int cnt, cx, cy, xmn, xmx, ymn, ymx, tv;
   } vec_t;

   localparam int LAT = 66;

   int n_cmp = 0;
   int n_bad = 0;
   int lat, pulses;
   int cap_cnt, cap_cx, cap_cy, cap_xmn, cap_xmx, cap_ymn, cap_ymx, cap_tv;
   vec_t vecs [7];

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One line: href high for len pixels, white for x in [wx0,wx1], junk on bits 31:1.
   task automatic drive_line(input int len, input int wx0, input int wx1);
      logic [31:0] r;
      for (int x = 0; x < len; x++) begin
         r              = $urandom();
         href_in        = 1'b1;
         binary_data_in = {r[31:1], 1'((x >= wx0) && (x <= wx1))};
         tick();
      end
      href_in        = 1'b0;
      binary_data_in = '0;
      tick();
      tick();
   endtask

   task automatic drive_frame(input int y0, input int nrows, input int len,
                              input int wx0, input int wx1);
      for (int i = 0; i < y0; i++) drive_line(1, 1, 0);
      for (int i = 0; i < nrows; i++) drive_line(len, wx0, wx1);
   endtask

   // Raise vsync (edge 0 is the next clock edge) and watch 150 edges for result pulses.
   task automatic frame_end(input int second_at, input int rst_at);
      lat = -1; pulses = 0;
      cap_cnt = -1; cap_cx = -1; cap_cy = -1; cap_xmn = -1;
      cap_xmx = -1; cap_ymn = -1; cap_ymx = -1; cap_tv = -1;
      vsync_in = 1'b1;
      for (int e = 0; e < 150; e++) begin
         @(posedge clk);
         #1;
         if (result_valid) begin
            pulses++;
            if (lat < 0) begin
               lat     = e;
               cap_cnt = int'(pixel_count);
               cap_cx  = int'(centroid_x);
               cap_cy  = int'(centroid_y);
               cap_xmn = int'(x_min);
               cap_xmx = int'(x_max);
               cap_ymn = int'(y_min);
               cap_ymx = int'(y_max);
               cap_tv  = int'(target_valid);
            end
         end
         if (e == 3 || e == second_at + 3) vsync_in = 1'b0;
         if (second_at > 0 && e == second_at - 1) vsync_in = 1'b1;
         if (rst_at > 0 && e == rst_at - 1) rst_n = 1'b0;
         if (rst_at > 0 && e == rst_at) rst_n = 1'b1;
      end
   endtask

   task automatic check_res(input string tag, input vec_t v);
      chk({tag, ".latency"}, lat, LAT);
      chk({tag, ".pulses"}, pulses, 1);
      chk({tag, ".pixel_count"}, cap_cnt, v.cnt);
      chk({tag, ".centroid_x"}, cap_cx, v.cx);
      chk({tag, ".centroid_y"}, cap_cy, v.cy);
      chk({tag, ".x_min"}, cap_xmn, v.xmn);
      chk({tag, ".x_max"}, cap_xmx, v.xmx);
      chk({tag, ".y_min"}, cap_ymn, v.ymn);
      chk({tag, ".y_max"}, cap_ymx, v.ymx);
      chk({tag, ".target_valid"}, cap_tv, v.tv);
      chk({tag, ".hold_count"}, int'(pixel_count), v.cnt);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      vec_t v;
      //           y0   nr  len  wx0  wx1   cnt  cx   cy   xmn xmx  ymn  ymx tv
      vecs[0] = '{ 50,  1, 101, 100, 100,    1, 100,  50, 100,100,  50,  50, 0};
      vecs[1] = '{300, 10, 210, 200, 209,  100, 204, 304, 200,209, 300, 309, 1};
      vecs[2] = '{  0,  3,  20,   1,   0,    0,   0,   0,   0,  0,   0,   0, 0};
      vecs[3] = '{ 10,  1, 700,   0, 699,  640, 319,  10,   0,639,  10,  10, 1};
      vecs[4] = '{  0,  1,  63,   0,  62,   63,  31,   0,   0, 62,   0,   0, 0};
      vecs[5] = '{479,  2,  64,   0,  63,   64,  31, 479,   0, 63, 479, 479, 1};
      vecs[6] = '{  2,  3,   8,   5,   7,    9,   6,   3,   5,  7,   2,   4, 0};

      repeat (3) tick();
      rst_n = 1'b1;
      tick();
      chk("reset.result_valid", int'(result_valid), 0);
      chk("reset.pixel_count", int'(pixel_count), 0);
      chk("reset.centroid_x", int'(centroid_x), 0);
      chk("reset.x_min", int'(x_min), 0);
      chk("reset.target_valid", int'(target_valid), 0);

      for (int i = 0; i < 7; i++) begin
         drive_frame(vecs[i].y0, vecs[i].nrows, vecs[i].len, vecs[i].wx0, vecs[i].wx1);
         frame_end(0, 0);
         check_res($sformatf("vec%0d", i), vecs[i]);
      end

      // Second frame end 20 edges into division is dropped.
      drive_frame(vecs[6].y0, vecs[6].nrows, vecs[6].len, vecs[6].wx0, vecs[6].wx1);
      frame_end(20, 0);
      check_res("drop.frame1", vecs[6]);
      drive_frame(1, 1, 4, 3, 3);
      frame_end(0, 0);
      v = '{1, 1, 4, 3, 3, 1, 3, 1, 3, 3, 1, 1, 0};
      check_res("drop.frame3", v);

      // Reset asserted during DIV_Y aborts the publish.
      drive_frame(4, 2, 30, 10, 19);
      frame_end(0, 45);
      chk("rst.pulses", pulses, 0);
      chk("rst.pixel_count", int'(pixel_count), 0);
      chk("rst.centroid_x", int'(centroid_x), 0);
      chk("rst.centroid_y", int'(centroid_y), 0);
      chk("rst.x_max", int'(x_max), 0);
      chk("rst.y_max", int'(y_max), 0);
      chk("rst.target_valid", int'(target_valid), 0);
      drive_frame(4, 2, 30, 10, 19);
      frame_end(0, 0);
      v = '{4, 2, 30, 10, 19, 20, 14, 4, 10, 19, 4, 5, 0};
      check_res("rst.next", v);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/binary_centroid.md
# binary_centroid

Frame-statistics stage directly downstream of the binary thresholding stage in the camera pipeline. It consumes the 32-bit binary pixel stream with its vsync/href framing and accumulates white-pixel count, bounding box and coordinate sums over each frame. At frame end it computes the integer centroid with a shared sequential divider. The result is published once per frame to the robotic-arm target-tracking logic.

## Interface
- `H_ACTIVE`, 640: active pixels per line; further pixels in a line are ignored.
- `V_ACTIVE`, 480: active lines per frame; further lines are ignored.
- `MIN_PIXELS`, 64: minimum white-pixel count for `target_valid`.
- `DIV_W`, 32: divider width; also the width of the x/y sum accumulators.
- `clk` in 1: pipeline clock.
- `rst_n` in 1: asynchronous active-low reset.
- `vsync_in` in 1: high during vertical blanking; rising edge marks frame end.
- `href_in` in 1: high while active pixels are on `binary_data_in`.
- `binary_data_in` in 32: binary pixel; white iff bit 0 = 1, bits 31:1 ignored.
- `x_min`, `x_max` out 10: bounding-box columns.
- `y_min`, `y_max` out 9: bounding-box rows.
- `centroid_x` out 10, `centroid_y` out 9: floor(sum/count).
- `pixel_count` out 19: white pixels in the last frame.
- `target_valid` out 1: last frame had `pixel_count >= MIN_PIXELS`.
- `result_valid` out 1: one-cycle pulse when all result outputs update.

## Operation
- Counters:
  - `x` counts sampled pixels within a line and clears when `href_in` is low.
  - `y` increments on each href falling edge and clears while `vsync_in` is high.
  - A pixel is accumulated only when `href_in`=1, `x < H_ACTIVE` and `y < V_ACTIVE`.
- Per white pixel:
  - count += 1; sum_x += x; sum_y += y.
  - Update min/max. Running min resets to all-ones and running max to 0 at frame start.
- Frame end is `vsync_in` 0→1, detected against a registered copy of `vsync_in`. On that edge:
  - Snapshot count, sums and box into holding registers.
  - Clear the running accumulators.
  - Move FSM IDLE→DIV_X.
- FSM:
  - IDLE: wait for frame end.
  - DIV_X: divide sum_x by count, `DIV_W` cycles, then go to DIV_Y.
  - DIV_Y: divide sum_y by count, `DIV_W` cycles, then go to PUBLISH.
  - PUBLISH: load all outputs, pulse `result_valid`, return to IDLE.
- Zero count: the divider still runs (fixed latency). PUBLISH forces centroid and box outputs to 0, `pixel_count`=0 and `target_valid`=0.
- Count in 1..MIN_PIXELS-1: values are reported normally with `target_valid`=0.
- A frame end while the FSM is not IDLE is dropped. No snapshot is taken, the running accumulators still clear, and the in-flight result completes unchanged.
- Outputs hold their values between publishes.
- Accumulation of the next frame runs concurrently with division.
- Reset values: all outputs 0, FSM in IDLE, accumulators cleared, min registers all-ones. `rst_n` asserted mid-division aborts the division with no publish.

## Timing
- Pixel sampling is registered. A white pixel presented at edge n contributes to the snapshot if frame end is detected at edge n+1 or later.
- Frame end is detected at edge 0, the first edge with `vsync_in`=1 after `vsync_in`=0.
- `result_valid` is high for exactly one cycle following edge 2·`DIV_W`+2 (66 for defaults). Outputs carry the new values in that same cycle.
- Divider: restoring, one quotient bit per cycle, MSB first, unsigned.
- Quotient is truncated to the output width; the quotient is always ≤ max coordinate, so no overflow.

## Structure
- Package `binary_centroid_pkg`:
  - FSM state enum (IDLE, DIV_X, DIV_Y, PUBLISH).
  - Width constants for x (10), y (9) and count (19) derived from the defaults.
- Sub-module `seq_divider`:
  - Ports: start/busy/done, dividend, divisor, quotient.
  - Parameter `DIV_W`.
  - Instantiated once and shared between DIV_X and DIV_Y.

## Test plan
- Single white pixel at (100,50) in an otherwise black 640×480 frame:
  - centroid (100,50), box 100..100/50..50, count 1, `target_valid`=0.
  - `result_valid` pulses 66 cycles after the vsync rising edge.
- White rectangle x 200..209, y 300..309:
  - count 100, centroid (204,304), box 200..209/300..309, `target_valid`=1.
- All-black frame: all outputs 0, `target_valid`=0, `result_valid` still pulses at cycle 66.
- Line of 700 white pixels at y=10: count 640, x_max 639, centroid (319,10).
- Second vsync rising edge 20 cycles after the first:
  - Only one `result_valid`, carrying frame-1 values.
  - A third frame then reports correctly.
- `rst_n` pulsed during DIV_Y:
  - No `result_valid`, all outputs 0.
  - The next full frame reports correctly.
